// File: rtl/mem_port_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_mem_pkg
//  Description : Shared types and constants for the memory port arbiter:
//                FSM state encoding, requester port IDs and latency counter
//                sizing.
//  Revision    : 1.0 - initial release
// ============================================================================
package cpu_mem_pkg;

    // Arbiter sequencing states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    // Requester identifiers (also the encoding of the last-grant pointer)
    localparam logic PORT_IF = 1'b0;
    localparam logic PORT_D  = 1'b1;

    // Largest supported read latency and the counter width needed to hold it
    localparam int RD_LAT_MAX = 4;
    localparam int CNT_W      = $clog2(RD_LAT_MAX + 1);

endpackage
`default_nettype wire

// File: rtl/mem_port_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : mem_port_arbiter_if
//  Description : Bundles the fetch port, data port and memory macro signals
//                of the arbiter. 'slave' is the arbiter view, 'master' is the
//                view of the surrounding core plus memory.
//  Revision    : 1.0 - initial release
// ============================================================================
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    // Instruction-fetch port
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt;
    logic              if_rvalid;
    logic [DATA_W-1:0] if_rdata;

    // Load/store data port
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_gnt;
    logic              d_rvalid;
    logic [DATA_W-1:0] d_rdata;

    // Memory macro side
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
               mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
               mem_en, mem_we, mem_addr, mem_wdata
    );

endinterface
`default_nettype wire

// File: rtl/mem_port_arbiter_pick.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arb_pick
//  Description : Combinational winner select between the fetch and data
//                requesters. Default: data port has fixed priority.
//                With MEM_ARB_RR_EN defined: round-robin on contention, the
//                port not named by the last-grant pointer wins.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_arb_pick
    import cpu_mem_pkg::*;
(
    input  wire logic i_if_req,
    input  wire logic i_d_req,
    input  wire logic i_last_ptr,
    output logic      o_valid,
    output logic      o_winner
);

`ifndef MEM_ARB_RR_EN
    // Pointer is maintained by the parent but only consulted in round-robin mode
    logic w_unused_last_ptr;
    assign w_unused_last_ptr = i_last_ptr;
`endif

    // Select the winning port; a lone request always wins
    always_comb begin
        o_valid  = i_if_req | i_d_req;
        o_winner = i_d_req ? PORT_D : PORT_IF;
`ifdef MEM_ARB_RR_EN
        if (i_if_req && i_d_req) begin
            o_winner = ~i_last_ptr;
        end
`endif
    end

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_port_arbiter
//  Description : Shares a single-ported synchronous RAM between the fetch and
//                data requesters. Grants are combinational in IDLE/RESP,
//                writes complete in the grant cycle, reads are tracked by a
//                latency counter (RD_LAT legal range 1..4) and returned with
//                a one-cycle rvalid pulse. Optional macro MEM_ARB_RR_EN
//                switches contention handling to round-robin.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter
    import cpu_mem_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16,
    parameter int RD_LAT = 1
) (
    input  wire logic         clk,
    input  wire logic         reset,
    mem_port_arbiter_if.slave bus,
    output logic              busy
);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              owner_q, owner_d;
    logic              last_ptr_q, last_ptr_d;
    logic              if_rvalid_q, if_rvalid_d;
    logic              d_rvalid_q, d_rvalid_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;

    logic              w_pick_valid;
    logic              w_pick_winner;
    logic              w_gnt;
    logic              w_read;
    logic [ADDR_W-1:0] w_sel_addr;

    mem_arb_pick u_pick (
        .i_if_req   (bus.if_req),
        .i_d_req    (bus.d_req),
        .i_last_ptr (last_ptr_q),
        .o_valid    (w_pick_valid),
        .o_winner   (w_pick_winner)
    );

    // Grant and memory strobe: arbitration is closed while a read is in WAIT
    // and everything is forced quiet while reset is held low
    always_comb begin
        w_gnt      = reset && (state_q != ST_WAIT) && w_pick_valid;
        w_read     = w_gnt && ((w_pick_winner == PORT_IF) || !bus.d_we);
        w_sel_addr = (w_pick_winner == PORT_D) ? bus.d_addr : bus.if_addr;

        bus.if_gnt    = w_gnt && (w_pick_winner == PORT_IF);
        bus.d_gnt     = w_gnt && (w_pick_winner == PORT_D);
        bus.mem_en    = w_gnt;
        bus.mem_we    = w_gnt && (w_pick_winner == PORT_D) && bus.d_we;
        bus.mem_addr  = w_gnt ? w_sel_addr : '0;
        bus.mem_wdata = (w_gnt && (w_pick_winner == PORT_D)) ? bus.d_wdata : '0;
    end

    // Next-state logic: latency countdown, read data capture, pointer update
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        owner_d     = owner_q;
        last_ptr_d  = last_ptr_q;
        if_rvalid_d = 1'b0;
        d_rvalid_d  = 1'b0;
        if_rdata_d  = if_rdata_q;
        d_rdata_d   = d_rdata_q;

        case (state_q)
            ST_WAIT: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_RESP;
                    if (owner_q == PORT_D) begin
                        d_rdata_d  = bus.mem_rdata;
                        d_rvalid_d = 1'b1;
                    end else begin
                        if_rdata_d  = bus.mem_rdata;
                        if_rvalid_d = 1'b1;
                    end
                end
            end
            default: begin
                // IDLE and RESP both arbitrate; a new read overlaps RESP
                if (w_read) begin
                    state_d = ST_WAIT;
                    cnt_d   = CNT_W'(RD_LAT);
                    owner_d = w_pick_winner;
                end else begin
                    state_d = ST_IDLE;
                end
            end
        endcase

        if (w_gnt) begin
            last_ptr_d = w_pick_winner;
        end
    end

    // State and registered outputs; async reset drops any pending response
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            owner_q     <= PORT_IF;
            last_ptr_q  <= PORT_D;
            if_rvalid_q <= 1'b0;
            d_rvalid_q  <= 1'b0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            owner_q     <= owner_d;
            last_ptr_q  <= last_ptr_d;
            if_rvalid_q <= if_rvalid_d;
            d_rvalid_q  <= d_rvalid_d;
            if_rdata_q  <= if_rdata_d;
            d_rdata_q   <= d_rdata_d;
        end
    end

    assign bus.if_rvalid = if_rvalid_q;
    assign bus.d_rvalid  = d_rvalid_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.d_rdata   = d_rdata_q;
    assign busy          = (state_q == ST_WAIT) || (state_q == ST_RESP);

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_port_arbiter
//  Description : Self-checking bench for mem_port_arbiter. A synchronous RAM
//                model answers reads after LAT cycles; a per-cycle monitor
//                predicts grants/strobes and pushes expected read responses
//                into a scoreboard that is popped when rvalid is due.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

    localparam int AW  = 16;
    localparam int DW  = 16;
    localparam int LAT = 2;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    logic busy;

    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(LAT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus),
        .busy  (busy)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // Synchronous RAM model with LAT-cycle read pipeline
    logic [DW-1:0] mem    [256] = '{default: '0};
    logic [DW-1:0] pipe_d [LAT] = '{default: '0};
    logic          pipe_v [LAT] = '{default: 1'b0};

    always @(posedge clk) begin
        if (bus.mem_en && bus.mem_we) mem[bus.mem_addr[7:0]] <= bus.mem_wdata;
        pipe_v[0] <= bus.mem_en && !bus.mem_we;
        pipe_d[0] <= mem[bus.mem_addr[7:0]];
        for (int i = 1; i < LAT; i++) begin
            pipe_v[i] <= pipe_v[i-1];
            pipe_d[i] <= pipe_d[i-1];
        end
    end

    assign bus.mem_rdata = pipe_v[LAT-1] ? pipe_d[LAT-1] : 16'h0BAD;

    // Scoreboard of expected read responses
    typedef struct {
        logic          port;
        int            due;
        logic [DW-1:0] data;
    } exp_t;
    exp_t sb[$];

    int   blocked_until = -1;
    int   last_rd       = -100;
    logic m_ptr         = 1'b1;

    // Per-cycle prediction and comparison, sampled mid-cycle
    always @(negedge clk) begin
        logic          e_gnt, e_win, e_we, e_read, e_busy;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_wd;
        exp_t          e;
        if (!reset) begin
            sb.delete();
            blocked_until = -1;
            last_rd       = -100;
            m_ptr         = 1'b1;
            check("rst_if_gnt",    32'(bus.if_gnt),    0);
            check("rst_d_gnt",     32'(bus.d_gnt),     0);
            check("rst_mem_en",    32'(bus.mem_en),    0);
            check("rst_mem_addr",  32'(bus.mem_addr),  0);
            check("rst_if_rvalid", 32'(bus.if_rvalid), 0);
            check("rst_d_rvalid",  32'(bus.d_rvalid),  0);
            check("rst_if_rdata",  32'(bus.if_rdata),  0);
            check("rst_d_rdata",   32'(bus.d_rdata),   0);
            check("rst_busy",      32'(busy),          0);
        end else begin
            e_gnt = (cyc > blocked_until) && (bus.if_req || bus.d_req);
            e_win = bus.d_req;
`ifdef MEM_ARB_RR_EN
            if (bus.if_req && bus.d_req) e_win = ~m_ptr;
`endif
            e_we   = e_gnt && e_win && bus.d_we;
            e_read = e_gnt && !e_we;
            e_addr = !e_gnt ? '0 : (e_win ? bus.d_addr : bus.if_addr);
            e_wd   = (e_gnt && e_win) ? bus.d_wdata : '0;
            e_busy = (cyc > last_rd) && (cyc <= last_rd + LAT + 1);

            check("if_gnt",    32'(bus.if_gnt),    32'(e_gnt && !e_win));
            check("d_gnt",     32'(bus.d_gnt),     32'(e_gnt && e_win));
            check("mem_en",    32'(bus.mem_en),    32'(e_gnt));
            check("mem_we",    32'(bus.mem_we),    32'(e_we));
            check("mem_addr",  32'(bus.mem_addr),  32'(e_addr));
            check("mem_wdata", 32'(bus.mem_wdata), 32'(e_wd));
            check("busy",      32'(busy),          32'(e_busy));

            if (sb.size() > 0 && sb[0].due == cyc) begin
                e = sb.pop_front();
                check("if_rvalid", 32'(bus.if_rvalid), 32'(e.port == 1'b0));
                check("d_rvalid",  32'(bus.d_rvalid),  32'(e.port == 1'b1));
                check(e.port ? "d_rdata" : "if_rdata",
                      32'(e.port ? bus.d_rdata : bus.if_rdata), 32'(e.data));
            end else begin
                check("if_rvalid_idle", 32'(bus.if_rvalid), 0);
                check("d_rvalid_idle",  32'(bus.d_rvalid),  0);
            end

            if (e_gnt) m_ptr = e_win;
            if (e_read) begin
                sb.push_back('{port: e_win, due: cyc + LAT + 1, data: mem[e_addr[7:0]]});
                blocked_until = cyc + LAT;
                last_rd       = cyc;
            end
        end
    end

    // Drivers: called just after a rising edge, return just after one
    task automatic wait_gnt(input logic port);
        bit got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            got = port ? bus.d_gnt : bus.if_gnt;
        end
        check(port ? "d_gnt_seen" : "if_gnt_seen", 32'(got), 1);
        @(posedge clk); #1;
    endtask

    task automatic if_read(input logic [AW-1:0] a);
        bus.if_req  = 1'b1;
        bus.if_addr = a;
        wait_gnt(1'b0);
        bus.if_req  = 1'b0;
    endtask

    task automatic d_access(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] wd);
        bus.d_req   = 1'b1;
        bus.d_we    = we;
        bus.d_addr  = a;
        bus.d_wdata = wd;
        wait_gnt(1'b1);
        bus.d_req   = 1'b0;
        bus.d_we    = 1'b0;
    endtask

    task automatic idle(input int n);
        if (n > 0) begin
            repeat (n) @(posedge clk);
            #1;
        end
    endtask

    initial begin
        bus.if_req = 1'b0; bus.if_addr = '0;
        bus.d_req  = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;

        // Reset held with both requesters active
        #2 reset = 1'b0;
        bus.if_req = 1'b1; bus.d_req = 1'b1;
        idle(3);
        bus.if_req = 1'b0; bus.d_req = 1'b0;
        reset = 1'b1;
        idle(3);

        // Preload and back-to-back writes
        d_access(1'b1, 16'h0004, 16'h1234);
        d_access(1'b1, 16'h0020, 16'hBEEF);
        d_access(1'b1, 16'h0010, 16'hAAAA);
        d_access(1'b1, 16'h0012, 16'h5555);
        idle(2);

        // Lone fetch read
        if_read(16'h0004);
        idle(LAT + 2);

        // Contention: data wins, fetch granted in the response cycle
        fork
            if_read(16'h0008);
            d_access(1'b0, 16'h0020, 16'h0);
        join
        idle(LAT + 2);

        // Back-to-back data reads, second overlaps the first response
        d_access(1'b0, 16'h0010, 16'h0);
        d_access(1'b0, 16'h0012, 16'h0);
        idle(LAT + 2);

        // Mixed random traffic on both ports
        fork
            for (int k = 0; k < 10; k++) begin
                if_read(AW'($urandom_range(0, 31)) << 1);
                idle($urandom_range(0, 2));
            end
            for (int k = 0; k < 12; k++) begin
                d_access(1'($urandom_range(0, 1)), AW'($urandom_range(0, 31)) << 1,
                         DW'($urandom));
                idle($urandom_range(0, 2));
            end
        join
        idle(LAT + 2);

        // Reset one cycle after a read grant: response must be dropped
        d_access(1'b0, 16'h0012, 16'h0);
        reset = 1'b0;
        idle(2);
        reset = 1'b1;
        bus.if_req  = 1'b1;
        bus.if_addr = 16'h0004;
        @(negedge clk);
        check("post_rst_gnt", 32'(bus.if_gnt), 1);
        @(posedge clk); #1;
        bus.if_req = 1'b0;

        // Drain outstanding responses
        for (int i = 0; i < 20 && sb.size() > 0; i++) @(posedge clk);
        idle(2);
        check("sb_drained", 32'(sb.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares the single-ported data/instruction memory between two requesters: the instruction-fetch port, driven by the PC stage, and the data port, driven by load/store execution. It sequences each access with a req/gnt/rvalid handshake and tracks read latency with an internal counter. It sits between the CPU core and the memory macro, and lets the memory be a synchronous RAM with configurable read latency.

Parameters:
ADDR_W, 16, address width (matches PC width)
DATA_W, 16, data word width
RD_LAT, 1, memory read latency in cycles from mem_en to valid mem_rdata; legal range 1..4

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
if_req  in  1  fetch read request; held until if_gnt
if_addr  in  ADDR_W  fetch address; stable while if_req is high
if_gnt  out  1  fetch request accepted this cycle
if_rvalid  out  1  one-cycle pulse; if_rdata is valid
if_rdata  out  DATA_W  fetched instruction word
d_req  in  1  data request; held until d_gnt
d_we  in  1  1 = write, 0 = read; stable while d_req is high
d_addr  in  ADDR_W  data address
d_wdata  in  DATA_W  write data
d_gnt  out  1  data request accepted this cycle
d_rvalid  out  1  one-cycle pulse; d_rdata is valid
d_rdata  out  DATA_W  load data
mem_en  out  1  memory access strobe
mem_we  out  1  memory write enable; only asserted together with mem_en
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data, valid RD_LAT cycles after mem_en
busy  out  1  a read is outstanding (state WAIT or RESP)

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, latency counter=0, rvalid outputs=0, rdata outputs=0, last-grant pointer=DATA.
  - Combinational outputs (gnt, mem_*) are 0 while reset is low.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - If any request is present, pick a winner and assert its gnt combinationally in the same cycle.
  - mem_en=1; mem_addr, mem_we and mem_wdata come from the winner. if_req always gives mem_we=0.
  - Write winner: access completes in that cycle; stay in IDLE, so back-to-back grants are allowed every cycle. No rvalid for writes.
  - Read winner: latch port ID, load counter=RD_LAT, go to WAIT.
- WAIT:
  - No grants; mem_en=0. Counter decrements each cycle.
  - At counter==1, capture mem_rdata into the owning port's rdata register and go to RESP.
- RESP:
  - Owning rvalid=1 for exactly this cycle; rdata holds its value until that port's next read.
  - Arbitration behaves as in IDLE in this same cycle (overlap allowed). The next state follows the IDLE rules.
- Read timing: gnt at cycle T, mem_rdata sampled at end of T+RD_LAT, rvalid at T+RD_LAT+1.
- When no grant: mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0.
- Priority (default): data port wins over fetch when both request, so a load/store in flight is never blocked by the next fetch. A losing requester keeps req high; its gnt stays 0.
- The last-grant pointer updates on every grant (used only by the optional feature).
- Only one read outstanding at a time. A requester must not drop req before gnt (protocol violation; behaviour unspecified).
- Reset asserted mid-WAIT/RESP: the pending response is dropped and rvalid is never pulsed; requesters re-issue after reset.

Optional Feature:
- Macro: MEM_ARB_RR_EN.
- Defined: round-robin between the ports. When both request, the port not named by the last-grant pointer wins. A lone request always wins.
- Undefined: fixed data-over-fetch priority; the pointer is still maintained but unused.

Decomposition:
- Package cpu_mem_pkg:
  - state enum (IDLE/WAIT/RESP)
  - port ID constants PORT_IF=0, PORT_D=1
  - RD_LAT_MAX=4 and counter width constant
- Sub-module mem_arb_pick: combinational winner select from if_req, d_req and the last-grant pointer, containing the MEM_ARB_RR_EN logic. The FSM, counter and data capture stay in mem_port_arbiter.

Test Plan:
- Reset: hold reset=0 with both reqs high -> all gnt/rvalid/mem_en=0. Release with no reqs -> remains idle, busy=0.
- Fetch read, RD_LAT=1: if_req with if_addr=0x0004 at T; memory returns 0x1234 at T+1 -> if_gnt=1 and mem_addr=0x0004 at T; if_rvalid=1 with if_rdata=0x1234 at T+2; d_rvalid stays 0.
- Contention, fixed priority: if_req and d_req (read 0x0020→0xBEEF) both high at T -> d_gnt at T, d_rvalid with 0xBEEF at T+2, if_gnt at T+2.
- Back-to-back writes: d_we=1 to 0x0010 and 0x0012 with data 0xAAAA, 0x5555 -> d_gnt and mem_we=1 on two consecutive cycles with matching addr/data; no rvalid.
- MEM_ARB_RR_EN defined, RD_LAT=2, both reqs held high -> grant order D, IF, D, IF, with gaps of RD_LAT+1 cycles between grants.
- Reset mid-read, RD_LAT=3: assert reset one cycle after d_gnt -> d_rvalid never pulses; after release, state is IDLE and a new request is granted immediately.
